// File: rtl/test_csr_mmio_responder_pkg.sv
// Shared types and address map for the test CSR MMIO responder.
package test_csr_mmio_responder_pkg;

   localparam int NUM_TEST_CSRS    = 8;
   localparam int NUM_COUNTER_BITS = 24;
   localparam int CSR_IDX_W        = (NUM_TEST_CSRS > 1) ? $clog2(NUM_TEST_CSRS) : 1;

   typedef logic [NUM_COUNTER_BITS-1:0] t_cci_test_counter;

   // Byte offsets of the fixed registers in the MMIO map
   localparam int unsigned DFH_OFFSET      = 'h00;
   localparam int unsigned AFU_ID_L_OFFSET = 'h08;
   localparam int unsigned AFU_ID_H_OFFSET = 'h10;
   localparam int unsigned STATUS_OFFSET   = 'h30;
   localparam int unsigned CSR_BASE_OFFSET = 'h40;

   localparam logic [63:0] DFH_VALUE_DEFAULT = 64'h1000_0000_0000_0000;

   typedef enum logic [1:0] {
      MMIO_LEN_4B    = 2'd0,
      MMIO_LEN_8B    = 2'd1,
      MMIO_LEN_RSVD2 = 2'd2,
      MMIO_LEN_RSVD3 = 2'd3
   } t_mmio_len;

   // Source selected by the read mux for one response
   typedef enum logic [2:0] {
      RD_SEL_ZERO   = 3'd0,
      RD_SEL_DFH    = 3'd1,
      RD_SEL_AFU_L  = 3'd2,
      RD_SEL_AFU_H  = 3'd3,
      RD_SEL_STATUS = 3'd4,
      RD_SEL_CSR    = 3'd5
   } t_rd_sel;

   typedef struct packed {
      logic [15:0]       err_cnt;
      t_cci_test_counter wr_cnt;
      t_cci_test_counter rd_cnt;
   } t_status;

   typedef struct packed {
      logic [63:0] data;
   } t_cpu_rd_csr;

   typedef struct packed {
      logic        en;
      logic [63:0] data;
   } t_cpu_wr_csr;

   // Quadword index of a byte offset, matching mmio_addr[15:1]
   function automatic logic [14:0] byte_to_qw(input int unsigned off);
      return 15'(off >> 3);
   endfunction

endpackage

// File: rtl/test_csrs.sv
// Bundle shared by the CSR manager and every test module.
interface test_csrs
   import test_csr_mmio_responder_pkg::*;
();
   logic [127:0]                   afu_id;
   t_cpu_rd_csr [NUM_TEST_CSRS-1:0] cpu_rd_csrs;
   t_cpu_wr_csr [NUM_TEST_CSRS-1:0] cpu_wr_csrs;

   modport csr  (input afu_id, input cpu_rd_csrs, output cpu_wr_csrs);
   modport test (output afu_id, output cpu_rd_csrs, input cpu_wr_csrs);
endinterface

// File: rtl/test_csr_rd_pipe.sv
// Two-stage read response pipeline: stage 1 holds tid/select/index and the
// status snapshot taken in the request cycle, stage 2 holds the muxed data.
// Handshake: req_valid is a one-cycle request with no ready (always
// accepted); rsp_valid is a one-cycle response with no ready (host cannot
// stall), asserted exactly two cycles after req_valid.
module test_csr_rd_pipe
   import test_csr_mmio_responder_pkg::*;
#(
   parameter logic [63:0] DFH_VALUE = DFH_VALUE_DEFAULT
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            req_valid,
   input  logic [8:0]                      req_tid,
   input  t_rd_sel                         req_sel,
   input  logic [CSR_IDX_W-1:0]            req_idx,
   input  t_status                         req_status,
   input  logic [127:0]                    afu_id,
   input  t_cpu_rd_csr [NUM_TEST_CSRS-1:0] rd_csrs,
   output logic                            rsp_valid,
   output logic [8:0]                      rsp_tid,
   output logic [63:0]                     rsp_data
);

   logic                 s1_valid_q, s1_valid_d;
   logic [8:0]           s1_tid_q, s1_tid_d;
   t_rd_sel              s1_sel_q, s1_sel_d;
   logic [CSR_IDX_W-1:0] s1_idx_q, s1_idx_d;
   t_status              s1_status_q, s1_status_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [8:0]           rsp_tid_q, rsp_tid_d;
   logic [63:0]          rsp_data_q, rsp_data_d;

   // Stage 1 captures the request; stage 2 selects the data source
   always_comb begin
      s1_valid_d  = req_valid;
      s1_tid_d    = req_tid;
      s1_sel_d    = req_sel;
      s1_idx_d    = req_idx;
      s1_status_d = req_status;

      rsp_valid_d = s1_valid_q;
      rsp_tid_d   = s1_valid_q ? s1_tid_q : rsp_tid_q;
      rsp_data_d  = rsp_data_q;
      if (s1_valid_q) begin
         case (s1_sel_q)
            RD_SEL_DFH:    rsp_data_d = DFH_VALUE;
            RD_SEL_AFU_L:  rsp_data_d = afu_id[63:0];
            RD_SEL_AFU_H:  rsp_data_d = afu_id[127:64];
            RD_SEL_STATUS: rsp_data_d = s1_status_q;
            RD_SEL_CSR:    rsp_data_d = rd_csrs[s1_idx_q].data;
            default:       rsp_data_d = 64'h0;
         endcase
      end
   end

   // Pipeline registers; reset discards any read in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s1_tid_q    <= '0;
         s1_sel_q    <= RD_SEL_ZERO;
         s1_idx_q    <= '0;
         s1_status_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_tid_q    <= s1_tid_d;
         s1_sel_q    <= s1_sel_d;
         s1_idx_q    <= s1_idx_d;
         s1_status_q <= s1_status_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_tid   = rsp_tid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: rtl/test_csr_mmio_responder.sv
// CSR-manager end of the test CSR bundle: decodes host MMIO, pulses test
// CSR writes, keeps traffic counters and answers reads via the read pipe.
// Handshake: mmio_rd_valid / mmio_wr_valid are one-cycle requests with no
// ready; every request is taken in the cycle it is presented. A read that
// collides with a write is dropped without a response and counted as an error.
module test_csr_mmio_responder
   import test_csr_mmio_responder_pkg::*;
#(
   parameter int unsigned CSR_BASE  = CSR_BASE_OFFSET,
   parameter logic [63:0] DFH_VALUE = DFH_VALUE_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mmio_wr_valid,
   input  logic        mmio_rd_valid,
   input  logic [15:0] mmio_addr,
   input  logic [1:0]  mmio_len,
   input  logic [8:0]  mmio_tid,
   input  logic [63:0] mmio_wdata,
   output logic        rsp_valid,
   output logic [8:0]  rsp_tid,
   output logic [63:0] rsp_data,
   test_csrs.csr       csrs
);

   localparam logic [14:0] CSR_QW      = byte_to_qw(CSR_BASE);
   localparam logic [14:0] DFH_QW      = byte_to_qw(DFH_OFFSET);
   localparam logic [14:0] AFU_ID_L_QW = byte_to_qw(AFU_ID_L_OFFSET);
   localparam logic [14:0] AFU_ID_H_QW = byte_to_qw(AFU_ID_H_OFFSET);
   localparam logic [14:0] STATUS_QW   = byte_to_qw(STATUS_OFFSET);

   logic [14:0]          qw;
   logic [14:0]          csr_off;
   logic                 csr_hit;
   logic [CSR_IDX_W-1:0] csr_idx;
   logic                 len_8b;
   logic                 rd_accept;
   logic                 collision;
   logic                 wr_csr_ok;
   logic                 wr_csr_bad;
   logic                 wr_accept;
   t_rd_sel              rd_sel;
   t_status              status;
   logic [1:0]           err_inc;
   logic [16:0]          err_sum;

   logic [NUM_TEST_CSRS-1:0]        wr_en_q, wr_en_d;
   logic [NUM_TEST_CSRS-1:0][63:0]  wr_data_q, wr_data_d;
   t_cci_test_counter               rd_cnt_q, rd_cnt_d;
   t_cci_test_counter               wr_cnt_q, wr_cnt_d;
   logic [15:0]                     err_cnt_q, err_cnt_d;

   // The host picks the 32-bit half of a 4B read, so addr[0] never matters
   logic unused_addr_lsb;
   assign unused_addr_lsb = mmio_addr[0];

   // Address decode and request classification
   always_comb begin
      qw         = mmio_addr[15:1];
      csr_off    = qw - CSR_QW;
      csr_hit    = (qw >= CSR_QW) && (csr_off < 15'(NUM_TEST_CSRS));
      csr_idx    = csr_off[CSR_IDX_W-1:0];
      len_8b     = (t_mmio_len'(mmio_len) == MMIO_LEN_8B);
      collision  = mmio_rd_valid & mmio_wr_valid;
      rd_accept  = mmio_rd_valid & ~mmio_wr_valid;
      wr_csr_ok  = mmio_wr_valid & csr_hit & len_8b;
      wr_csr_bad = mmio_wr_valid & csr_hit & ~len_8b;
      wr_accept  = mmio_wr_valid & ~wr_csr_bad;

      rd_sel = RD_SEL_ZERO;
      if (csr_hit)                rd_sel = RD_SEL_CSR;
      else if (qw == DFH_QW)      rd_sel = RD_SEL_DFH;
      else if (qw == AFU_ID_L_QW) rd_sel = RD_SEL_AFU_L;
      else if (qw == AFU_ID_H_QW) rd_sel = RD_SEL_AFU_H;
      else if (qw == STATUS_QW)   rd_sel = RD_SEL_STATUS;

      status.err_cnt = err_cnt_q;
      status.wr_cnt  = wr_cnt_q;
      status.rd_cnt  = rd_cnt_q;
   end

   // Next-state for write pulses, held write data and counters
   always_comb begin
      wr_en_d   = '0;
      wr_data_d = wr_data_q;
      if (wr_csr_ok) begin
         wr_en_d[csr_idx]   = 1'b1;
         wr_data_d[csr_idx] = mmio_wdata;
      end

      rd_cnt_d  = rd_cnt_q + NUM_COUNTER_BITS'(rd_accept);
      wr_cnt_d  = wr_cnt_q + NUM_COUNTER_BITS'(wr_accept);
      err_inc   = {1'b0, collision} + {1'b0, wr_csr_bad};
      err_sum   = {1'b0, err_cnt_q} + {15'b0, err_inc};
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   // Write pulse, write data and counter registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en_q   <= '0;
         wr_data_q <= '0;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   for (genvar gi = 0; gi < NUM_TEST_CSRS; gi++) begin : g_wr_csr
      assign csrs.cpu_wr_csrs[gi].en   = wr_en_q[gi];
      assign csrs.cpu_wr_csrs[gi].data = wr_data_q[gi];
   end

   test_csr_rd_pipe #(
      .DFH_VALUE (DFH_VALUE)
   ) u_rd_pipe (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (rd_accept),
      .req_tid    (mmio_tid),
      .req_sel    (rd_sel),
      .req_idx    (csr_idx),
      .req_status (status),
      .afu_id     (csrs.afu_id),
      .rd_csrs    (csrs.cpu_rd_csrs),
      .rsp_valid  (rsp_valid),
      .rsp_tid    (rsp_tid),
      .rsp_data   (rsp_data)
   );

endmodule
